// File: rtl/pixel_capture.sv
// pixel_capture
//   Captures an 8-bit camera stream (RGB565, high byte first) framed by
//   fval_i/lval_i. It emits one expanded 8:8:8 pixel per byte pair, together
//   with its column/row position.
//
// Ports
//   clk_25      : single clock for all logic
//   reset       : asynchronous, active-low reset
//   fval_i      : frame-valid from the camera
//   lval_i      : line-valid from the camera (only meaningful while fval_i=1)
//   data_i[7:0] : camera byte
//   valid       : one-cycle pixel strobe, never high on two consecutive cycles
//   x_o, y_o    : pixel column / row (held while valid=0)
//   red_o, green_o, blue_o : expanded colour (held while valid=0)
//   frame_done  : one-cycle pulse when the frame ends
//   byte_err    : sticky odd-byte-count flag, cleared at the next frame start
module pixel_capture #(
  parameter logic [9:0] H_ACTIVE = 10'd640,
  parameter logic [9:0] V_ACTIVE = 10'd480
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       fval_i,
  input  logic       lval_i,
  input  logic [7:0] data_i,
  output logic       valid,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic [7:0] red_o,
  output logic [7:0] green_o,
  output logic [7:0] blue_o,
  output logic       frame_done,
  output logic       byte_err
);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_HI, S_LO} state_t;

  state_t     r_state;
  logic       r_fval_prev;
  logic       r_lval_prev;
  logic       r_fval_armed;
  logic [7:0] r_hi;
  logic [9:0] r_col;
  logic [9:0] r_row;
  logic       r_valid;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic [7:0] r_red;
  logic [7:0] r_green;
  logic [7:0] r_blue;
  logic       r_frame_done;
  logic       r_byte_err;

  logic        w_fval_rise;
  logic        w_fval_fall;
  logic        w_lval_fall;
  logic [15:0] w_pix;
  logic [4:0]  w_r5;
  logic [5:0]  w_g6;
  logic [4:0]  w_b5;
  logic [9:0]  w_col_inc;
  logic [9:0]  w_row_inc;

  // r_fval_armed is cleared by reset and only set once fval_i has been seen
  // low, so a frame already in progress at reset release is never joined
  // half-way through.
  assign w_fval_rise = r_fval_armed & ~r_fval_prev & fval_i;
  assign w_fval_fall = r_fval_prev & ~fval_i;
  assign w_lval_fall = r_lval_prev & ~lval_i;

  assign w_pix = {r_hi, data_i};
  assign w_r5  = w_pix[15:11];
  assign w_g6  = w_pix[10:5];
  assign w_b5  = w_pix[4:0];

  assign w_col_inc = (r_col == 10'h3FF) ? r_col : r_col + 10'd1;
  assign w_row_inc = (r_row == 10'h3FF) ? r_row : r_row + 10'd1;

  always_ff @(posedge clk_25 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_fval_prev  <= 1'b0;
      r_lval_prev  <= 1'b0;
      r_fval_armed <= 1'b0;
      r_hi         <= 8'd0;
      r_col        <= 10'd0;
      r_row        <= 10'd0;
      r_valid      <= 1'b0;
      r_x          <= 10'd0;
      r_y          <= 10'd0;
      r_red        <= 8'd0;
      r_green      <= 8'd0;
      r_blue       <= 8'd0;
      r_frame_done <= 1'b0;
      r_byte_err   <= 1'b0;
    end else begin
      r_fval_prev  <= fval_i;
      r_lval_prev  <= lval_i;
      if (!fval_i) begin
        r_fval_armed <= 1'b1;
      end
      r_valid      <= 1'b0;
      r_frame_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_fval_rise) begin
            r_state    <= S_LINE;
            r_row      <= 10'd0;
            r_byte_err <= 1'b0;
          end
        end

        default: begin
          if (w_fval_fall) begin
            // Frame end; a partial pixel is dropped. The line rules still
            // apply when lval_i falls on the same cycle.
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
            if (w_lval_fall && (r_state != S_LINE)) begin
              r_row <= w_row_inc;
              if (r_state == S_LO) begin
                r_byte_err <= 1'b1;
              end
            end
          end else if (r_state == S_LINE) begin
            // The first byte of a line is consumed right here as the high
            // byte, so the next byte is already the low byte.
            if (lval_i) begin
              r_hi    <= data_i;
              r_col   <= 10'd0;
              r_state <= S_LO;
            end
          end else if (w_lval_fall) begin
            // Being in S_HI/S_LO implies at least one byte of this line.
            r_state <= S_LINE;
            r_row   <= w_row_inc;
            if (r_state == S_LO) begin
              r_byte_err <= 1'b1;
            end
          end else if (r_state == S_HI) begin
            r_hi    <= data_i;
            r_state <= S_LO;
          end else begin
            // S_LO: the pixel is complete. The S_LO -> S_HI -> S_LO cycle
            // guarantees at least one idle cycle between strobes.
            if ((r_col < H_ACTIVE) && (r_row < V_ACTIVE)) begin
              r_valid <= 1'b1;
              r_x     <= r_col;
              r_y     <= r_row;
              r_red   <= {w_r5, w_r5[4:2]};
              r_green <= {w_g6, w_g6[5:4]};
              r_blue  <= {w_b5, w_b5[4:2]};
            end
            r_col   <= w_col_inc;
            r_state <= S_HI;
          end
        end
      endcase
    end
  end

  assign valid      = r_valid;
  assign x_o        = r_x;
  assign y_o        = r_y;
  assign red_o      = r_red;
  assign green_o    = r_green;
  assign blue_o     = r_blue;
  assign frame_done = r_frame_done;
  assign byte_err   = r_byte_err;

endmodule
